// File: rtl/sensor_packet_rx_if.sv
// Bus bundle for sensor_packet_rx: the serial link input plus the
// demultiplexed sensor registers and status pulses.
// master: link driver / consumer side. slave: the receiver.
interface sensor_packet_rx_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 rx_bit_valid;
  logic                 rx_bit;
  logic [7:0]           sensor_out0;
  logic [7:0]           sensor_out1;
  logic [7:0]           sensor_out2;
  logic [7:0]           sensor_out3;
  logic [7:0]           sensor_out4;
  logic [7:0]           sensor_out5;
  logic [7:0]           sensor_out6;
  logic [7:0]           sensor_out7;
  logic [7:0]           update;
  logic                 error;
  logic                 seq_error;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  modport master (
    output rx_bit_valid, rx_bit,
    input  sensor_out0, sensor_out1, sensor_out2, sensor_out3,
           sensor_out4, sensor_out5, sensor_out6, sensor_out7,
           update, error, seq_error, err_count, busy
  );

  modport slave (
    input  rx_bit_valid, rx_bit,
    output sensor_out0, sensor_out1, sensor_out2, sensor_out3,
           sensor_out4, sensor_out5, sensor_out6, sensor_out7,
           update, error, seq_error, err_count, busy
  );
endinterface

// File: rtl/sensor_packet_rx.sv
// sensor_packet_rx: bit-serial deframer for 11-bit sensor packets
// (start, id[2:0] + data[7:0] MSB first, even parity, stop). Good frames
// land in the per-id output register; bad frames pulse error and bump a
// saturating counter; out-of-order ids pulse seq_error.
// Optional build macro SENSOR_RX_TIMEOUT_EN: aborts a frame after
// TIMEOUT_CYCLES clocks with no rx_bit_valid while busy.

// One sensor's output register, written only on an accepted frame.
module sensor_packet_rx_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // hold last accepted data for this id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= 8'h00;
    else if (we) dout <= din;
  end
endmodule

module sensor_packet_rx #(
  parameter int ERR_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  sensor_packet_rx_if.slave bus
);
  localparam int NUM_SENSORS = 8;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                          state_q, state_d;
  logic [3:0]                      bit_cnt_q;
  logic [10:0]                     shreg_q;
  logic                            par_q;
  logic [2:0]                      exp_id_q;
  logic [ERR_CNT_W-1:0]            err_cnt_q;
  logic [NUM_SENSORS-1:0]          update_q;
  logic                            error_q;
  logic                            seq_q;
  logic [NUM_SENSORS-1:0][7:0]     sensor_q;

  logic                            load_cnt, shift_en, cap_par, frame_done;
  logic                            frame_ok, accept, reject, to_hit, busy_w;
  logic [2:0]                      pkt_id;
  logic [7:0]                      pkt_data;

  assign busy_w   = (state_q != S_IDLE);
  assign pkt_id   = shreg_q[10:8];
  assign pkt_data = shreg_q[7:0];
  // stop bit is the live rx_bit on the STOP edge; parity is even over 12 bits
  assign frame_ok = bus.rx_bit & ~(^{shreg_q, par_q});
  assign accept   = frame_done & frame_ok;
  assign reject   = (frame_done & ~frame_ok) | to_hit;

`ifdef SENSOR_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // abort on the cycle the idle count would reach TIMEOUT_CYCLES
  assign to_hit = busy_w & ~bus.rx_bit_valid &
                  (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // count idle (no-strobe) cycles while mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   to_cnt_q <= '0;
    else if (!busy_w || bus.rx_bit_valid || to_hit) to_cnt_q <= '0;
    else                                          to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state and datapath strobes; only strobed edges advance the frame
  always_comb begin
    state_d    = state_q;
    load_cnt   = 1'b0;
    shift_en   = 1'b0;
    cap_par    = 1'b0;
    frame_done = 1'b0;
    if (bus.rx_bit_valid) begin
      unique case (state_q)
        S_IDLE: if (!bus.rx_bit) begin
          state_d  = S_DATA;
          load_cnt = 1'b1;
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt_q == 4'd0) state_d = S_PARITY;
        end
        S_PARITY: begin
          cap_par = 1'b1;
          state_d = S_STOP;
        end
        S_STOP: begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (to_hit) state_d = S_IDLE;
  end

  // shift register, bit counter and parity capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 4'd0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      if (load_cnt) bit_cnt_q <= 4'd10;
      else if (shift_en && bit_cnt_q != 4'd0) bit_cnt_q <= bit_cnt_q - 4'd1;
      if (shift_en) shreg_q <= {shreg_q[9:0], bus.rx_bit};
      if (cap_par)  par_q   <= bus.rx_bit;
    end
  end

  // single-cycle status pulses, expected-id tracking, error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_q  <= '0;
      error_q   <= 1'b0;
      seq_q     <= 1'b0;
      exp_id_q  <= 3'd0;
      err_cnt_q <= '0;
    end else begin
      update_q <= '0;
      error_q  <= 1'b0;
      seq_q    <= 1'b0;
      if (accept) begin
        update_q <= NUM_SENSORS'(1) << pkt_id;
        seq_q    <= (pkt_id != exp_id_q);
        exp_id_q <= pkt_id + 3'd1;
      end
      if (reject) begin
        error_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  // one output register per sensor id
  for (genvar k = 0; k < NUM_SENSORS; k++) begin : g_slot
    sensor_packet_rx_slot u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (accept && (pkt_id == 3'(k))),
      .din  (pkt_data),
      .dout (sensor_q[k])
    );
  end

  assign bus.sensor_out0 = sensor_q[0];
  assign bus.sensor_out1 = sensor_q[1];
  assign bus.sensor_out2 = sensor_q[2];
  assign bus.sensor_out3 = sensor_q[3];
  assign bus.sensor_out4 = sensor_q[4];
  assign bus.sensor_out5 = sensor_q[5];
  assign bus.sensor_out6 = sensor_q[6];
  assign bus.sensor_out7 = sensor_q[7];
  assign bus.update      = update_q;
  assign bus.error       = error_q;
  assign bus.seq_error   = seq_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.busy        = busy_w;
endmodule

// File: tb/tb_sensor_packet_rx.sv
// Scoreboard bench for sensor_packet_rx: frame tasks push expected pulse
// events, a negedge monitor pops and compares whenever a pulse appears.
module tb_sensor_packet_rx;
  logic clk;
  logic rst_n;
  sensor_packet_rx_if #(.ERR_CNT_W(8)) bus ();

  sensor_packet_rx #(.ERR_CNT_W(8), .TIMEOUT_CYCLES(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] upd;
    logic       err;
    logic       seq;
    logic [2:0] id;
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         gap   = 1;
  logic [2:0] m_exp;
  logic [7:0] m_cnt;
  logic [7:0] m_out [8];

  logic [7:0] tbl_data [8] = '{8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33, 8'h55, 8'h99, 8'h66};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input int k);
    case (k)
      0: return bus.sensor_out0;
      1: return bus.sensor_out1;
      2: return bus.sensor_out2;
      3: return bus.sensor_out3;
      4: return bus.sensor_out4;
      5: return bus.sensor_out5;
      6: return bus.sensor_out6;
      default: return bus.sensor_out7;
    endcase
  endfunction

  // monitor: every pulse cycle must match the next expected event
  always @(negedge clk) begin
    if (rst_n && (bus.update != 8'h00 || bus.error || bus.seq_error)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got upd=%0h err=%0b seq=%0b want none (t=%0t)",
                 bus.update, bus.error, bus.seq_error, $time);
      end else begin
        mon_e = q.pop_front();
        chk("update", bus.update, mon_e.upd);
        chk("error", bus.error, mon_e.err);
        chk("seq_error", bus.seq_error, mon_e.seq);
        chk("err_count", bus.err_count, mon_e.cnt);
        if (mon_e.upd != 8'h00) chk("sensor_out_written", rd(mon_e.id), mon_e.data);
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.rx_bit       = b;
    bus.rx_bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_bit_valid = 1'b0;
    bus.rx_bit       = 1'b1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [2:0] id, input logic [7:0] data,
                            input logic bad_par, input logic stop);
    logic [10:0] pkt;
    logic        par;
    exp_t        e;
    pkt = {id, data};
    par = (^pkt) ^ bad_par;
    send_bit(1'b0);
    for (int i = 10; i >= 0; i--) send_bit(pkt[i]);
    send_bit(par);
    if (stop && !bad_par) begin
      e.upd  = 8'h01 << id;
      e.err  = 1'b0;
      e.seq  = (id != m_exp);
      m_exp  = id + 3'd1;
      m_out[id] = data;
    end else begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      e.upd = 8'h00;
      e.err = 1'b1;
      e.seq = 1'b0;
    end
    e.id   = id;
    e.data = data;
    e.cnt  = m_cnt;
    q.push_back(e);
    send_bit(stop);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // assert reset (possibly mid-frame) and check reset values immediately
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("rst_sensor_out%0d", k), rd(k), 8'h00);
    chk("rst_update", bus.update, 8'h00);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_seq_error", bus.seq_error, 1'b0);
    chk("rst_err_count", bus.err_count, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    m_exp = 3'd0;
    m_cnt = 8'h00;
    for (int k = 0; k < 8; k++) m_out[k] = 8'h00;
    q.delete();
    bus.rx_bit_valid = 1'b0;
    bus.rx_bit       = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.rx_bit       = 1'b1;
    #12;
    do_reset();

    // id 3 with expected id 0: written and flagged out of sequence
    send_frame(3'd3, 8'h0F, 1'b0, 1'b1);
    drain();
    chk("t1_sensor_out3", bus.sensor_out3, 8'h0F);
    chk("t1_busy_idle", bus.busy, 1'b0);

    // ids 0..7 in order from reset: no sequence errors
    do_reset();
    for (int k = 0; k < 8; k++) send_frame(3'(k), tbl_data[k], 1'b0, 1'b1);
    drain();
    chk("t2_out0", bus.sensor_out0, 8'hAA);
    chk("t2_out3", bus.sensor_out3, 8'h0F);
    chk("t2_out7", bus.sensor_out7, 8'h66);
    chk("t2_err_count", bus.err_count, 8'h00);

    // parity error
    send_frame(3'd0, 8'hAA, 1'b1, 1'b1);
    drain();
    chk("t3_err_count", bus.err_count, 8'h01);
    chk("t3_out0_kept", bus.sensor_out0, 8'hAA);

    // stop bit 0, then a back-to-back good id 0 frame (expected id unchanged)
    send_frame(3'd0, 8'h55, 1'b0, 1'b0);
    gap = 0;
    send_frame(3'd0, 8'h3C, 1'b0, 1'b1);
    gap = 1;
    drain();
    chk("t4_err_count", bus.err_count, 8'h02);
    chk("t4_out0", bus.sensor_out0, 8'h3C);
    chk("t4_out1_kept", bus.sensor_out1, 8'hCC);

    // reset after 5 data bits, then a good frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("t5_busy_mid", bus.busy, 1'b1);
    #2;
    do_reset();
    send_frame(3'd5, 8'h81, 1'b0, 1'b1);
    drain();
    chk("t5_out5", bus.sensor_out5, 8'h81);

    // stall after the start bit
    do_reset();
`ifdef SENSOR_RX_TIMEOUT_EN
    begin
      exp_t e;
      e.upd = 8'h00; e.err = 1'b1; e.seq = 1'b0; e.id = 3'd0; e.data = 8'h00;
      m_cnt = 8'h01;
      e.cnt = m_cnt;
      q.push_back(e);
    end
    send_bit(1'b0);
    repeat (80) @(posedge clk);
    #1;
    chk("t6_busy_after_timeout", bus.busy, 1'b0);
    chk("t6_err_count", bus.err_count, 8'h01);
`else
    send_bit(1'b0);
    repeat (80) @(posedge clk);
    #1;
    chk("t6_busy_held", bus.busy, 1'b1);
`endif

    // error counter saturation with back-to-back bad frames
    do_reset();
    gap = 0;
    for (int i = 0; i < 257; i++) send_frame(3'(i), 8'(i), 1'b1, 1'b1);
    gap = 1;
    drain();
    chk("t7_err_count_sat", bus.err_count, 8'hFF);
    send_frame(3'd0, 8'h5A, 1'b0, 1'b1);
    drain();
    chk("t7_out0_after_sat", bus.sensor_out0, 8'h5A);

    for (int k = 0; k < 8; k++) chk($sformatf("final_out%0d", k), rd(k), m_out[k]);
    chk("scoreboard_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
